rmii_rx: RTL and testbench

RMII_RX -- requirements
Module: rmii_rx

---
 rtl/rmii_pkg.sv | 19 +
 rtl/eth_crc32_step.sv | 20 ++
 rtl/rmii_rx.sv | 139 +++++++++++++
 tb/tb_rmii_rx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rmii_pkg.sv
// rtl/rmii_pkg.sv - shared constants for the RMII receive path
package rmii_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PREAMBLE = 2'd1;
    localparam logic [1:0] ST_DATA     = 2'd2;
    localparam logic [1:0] ST_DROP     = 2'd3;

    localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0] SFD_DIBIT      = 2'b11;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    localparam logic [2:0] MIN_FRAME_LEN = 3'd5;
    localparam logic [2:0] FCS_LEN       = 3'd4;

endpackage

// File: rtl/eth_crc32_step.sv
// rtl/eth_crc32_step.sv - one-byte step of the reflected Ethernet CRC-32
module eth_crc32_step
    import rmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'd0, data_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/rmii_rx.sv
// rtl/rmii_rx.sv - RMII receiver: preamble/SFD detect, byte assembly, FCS strip and check
module rmii_rx
    import rmii_pkg::*;
#(
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rmii_d,
    input  logic                  rmii_er,
    input  logic                  rmii_en,
    input  logic                  rmii_clk_en,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  stat_rx_bad_fcs,
    output logic                  stat_rx_err
);

    logic [1:0]      state;
    logic [1:0]      dibit_cnt;
    logic [7:0]      acc;
    logic [31:0]     crc;
    logic [31:0]     crc_next;
    logic [3:0][7:0] dl;
    logic [2:0]      dl_cnt;
    logic [2:0]      byte_cnt;
    logic [7:0]      hold;
    logic            hold_vld;
    logic            err_sticky;
    logic [1:0]      d;
    logic [7:0]      byte_next;
    logic            byte_done;
    logic            crc_bad;

    assign d         = rmii_d[1:0];
    assign byte_next = {d, acc[7:2]};
    assign byte_done = (dibit_cnt == 2'd3);
    assign crc_bad   = (crc != CRC_RESIDUE);

    eth_crc32_step u_crc (
        .crc_in  (crc),
        .data_in (byte_next),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            dibit_cnt       <= 2'd0;
            acc             <= 8'd0;
            crc             <= CRC_INIT;
            dl              <= '0;
            dl_cnt          <= 3'd0;
            byte_cnt        <= 3'd0;
            hold            <= 8'd0;
            hold_vld        <= 1'b0;
            err_sticky      <= 1'b0;
            m_axis_tdata    <= 8'd0;
            m_axis_tvalid   <= 1'b0;
            m_axis_tlast    <= 1'b0;
            m_axis_tuser    <= 1'b0;
            stat_rx_bad_fcs <= 1'b0;
            stat_rx_err     <= 1'b0;
        end else begin
            m_axis_tvalid   <= 1'b0;
            m_axis_tlast    <= 1'b0;
            m_axis_tuser    <= 1'b0;
            stat_rx_bad_fcs <= 1'b0;
            stat_rx_err     <= 1'b0;
            if (rmii_clk_en) begin
                case (state)
                    ST_IDLE: begin
                        if (rmii_en && d == PREAMBLE_DIBIT) state <= ST_PREAMBLE;
                    end
                    ST_PREAMBLE: begin
                        if (!rmii_en) begin
                            state <= ST_IDLE;
                        end else if (d == SFD_DIBIT) begin
                            state      <= ST_DATA;
                            dibit_cnt  <= 2'd0;
                            crc        <= CRC_INIT;
                            dl_cnt     <= 3'd0;
                            byte_cnt   <= 3'd0;
                            hold_vld   <= 1'b0;
                            err_sticky <= 1'b0;
                        end else if (d != PREAMBLE_DIBIT) begin
                            state       <= ST_DROP;
                            stat_rx_err <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (rmii_en) begin
                            acc       <= byte_next;
                            dibit_cnt <= dibit_cnt + 2'd1;
                            if (rmii_er) begin
                                err_sticky <= 1'b1;
                                if (!err_sticky) stat_rx_err <= 1'b1;
                            end
                            // Four-byte delay keeps the FCS off the stream; dl[3] is oldest.
                            if (byte_done) begin
                                crc <= crc_next;
                                dl  <= {dl[2:0], byte_next};
                                if (byte_cnt != MIN_FRAME_LEN) byte_cnt <= byte_cnt + 3'd1;
                                if (dl_cnt == FCS_LEN) begin
                                    hold     <= dl[3];
                                    hold_vld <= 1'b1;
                                    if (hold_vld) begin
                                        m_axis_tvalid <= 1'b1;
                                        m_axis_tdata  <= hold;
                                    end
                                end else begin
                                    dl_cnt <= dl_cnt + 3'd1;
                                end
                            end
                        end else begin
                            state    <= ST_IDLE;
                            hold_vld <= 1'b0;
                            if (hold_vld) begin
                                m_axis_tvalid   <= 1'b1;
                                m_axis_tdata    <= hold;
                                m_axis_tlast    <= 1'b1;
                                m_axis_tuser    <= err_sticky | (dibit_cnt != 2'd0) | crc_bad;
                                stat_rx_bad_fcs <= crc_bad;
                                if (dibit_cnt != 2'd0) stat_rx_err <= 1'b1;
                            end
                            if (byte_cnt < MIN_FRAME_LEN) stat_rx_err <= 1'b1;
                        end
                    end
                    default: begin
                        if (!rmii_en) state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rmii_rx.sv
// tb/tb_rmii_rx.sv - directed self-checking bench for rmii_rx
module tb_rmii_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] rmii_d;
    logic       rmii_er;
    logic       rmii_en;
    logic       rmii_clk_en;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tlast;
    logic       m_axis_tuser;
    logic       stat_rx_bad_fcs;
    logic       stat_rx_err;

    int checks = 0;
    int fails  = 0;
    int div    = 1;
    int er_dibit = -1;
    int nbad = 0;
    int nerr = 0;
    int q_base = 0;
    int bad_base = 0;
    int err_base = 0;

    logic [9:0] rxq[$];
    time        rxt[$];
    logic [7:0] frm[$];

    rmii_rx #(.DATA_WIDTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .rmii_d          (rmii_d),
        .rmii_er         (rmii_er),
        .rmii_en         (rmii_en),
        .rmii_clk_en     (rmii_clk_en),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .stat_rx_bad_fcs (stat_rx_bad_fcs),
        .stat_rx_err     (stat_rx_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (m_axis_tvalid) begin
            rxq.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser});
            rxt.push_back($time);
        end
        if (stat_rx_bad_fcs) nbad++;
        if (stat_rx_err) nerr++;
    end

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input logic [1:0] d, input logic en, input logic er);
        @(negedge clk);
        rmii_d = d; rmii_en = en; rmii_er = er; rmii_clk_en = 1'b1;
        for (int k = 1; k < div; k++) begin
            @(negedge clk);
            rmii_clk_en = 1'b0;
        end
    endtask

    task automatic build_frame(input int plen, input bit flip);
        logic [31:0] c;
        logic [31:0] fcs;
        logic [7:0]  b;
        frm.delete();
        repeat (7) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < plen; i++) begin
            b = 8'(i + 1);
            frm.push_back(b);
            c = crc_byte(c, b);
        end
        fcs = ~c;
        frm.push_back(fcs[7:0]);
        frm.push_back(fcs[15:8]);
        frm.push_back(fcs[23:16]);
        frm.push_back(fcs[31:24]);
        if (flip) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
    endtask

    task automatic send_dibits(input int nbytes, input int extra);
        logic [7:0] b;
        int k = 0;
        for (int i = 0; i < nbytes; i++) begin
            b = frm[i];
            for (int j = 0; j < 4; j++) begin
                sample(b[2*j +: 2], 1'b1, k == er_dibit);
                k++;
            end
        end
        for (int j = 0; j < extra; j++) sample(2'b01, 1'b1, 1'b0);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) sample(2'b00, 1'b0, 1'b0);
    endtask

    task automatic check_frame(input string tag, input int n, input logic user_exp,
                               input int bad_exp, input int err_exp, input int spacing);
        int got;
        logic [9:0] e;
        got = rxq.size() - q_base;
        chk({tag, "_count"}, got, n);
        for (int i = 0; i < n && i < got; i++) begin
            e = rxq[q_base + i];
            chk({tag, "_data"}, e[9:2], 32'(i + 1));
            chk({tag, "_last"}, e[1], (i == n - 1));
            chk({tag, "_user"}, e[0], (i == n - 1) ? user_exp : 1'b0);
        end
        chk({tag, "_bad_fcs"}, nbad - bad_base, bad_exp);
        chk({tag, "_err"}, nerr - err_base, err_exp);
        if (spacing > 0 && got >= 2)
            chk({tag, "_spacing"}, 32'(rxt[q_base + 1] - rxt[q_base]), spacing);
        q_base = rxq.size();
        bad_base = nbad;
        err_base = nerr;
    endtask

    initial begin
        rst = 1'b1; rmii_d = 2'b00; rmii_er = 1'b0; rmii_en = 1'b0; rmii_clk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
                              stat_rx_bad_fcs, stat_rx_err}, 0);
        rst = 1'b0;
        send_idle(3);

        build_frame(5, 1'b0);
        send_dibits(frm.size(), 0);
        send_idle(4);
        check_frame("good", 5, 1'b0, 0, 0, 40);

        build_frame(5, 1'b1);
        send_dibits(frm.size(), 0);
        send_idle(4);
        check_frame("bad_fcs", 5, 1'b1, 1, 0, 40);

        div = 10;
        build_frame(5, 1'b0);
        send_dibits(frm.size(), 0);
        send_idle(4);
        check_frame("slow", 5, 1'b0, 0, 0, 400);
        div = 1;

        er_dibit = 41;
        build_frame(5, 1'b0);
        send_dibits(frm.size(), 0);
        send_idle(4);
        check_frame("rx_er", 5, 1'b1, 0, 1, 0);
        er_dibit = -1;

        build_frame(5, 1'b0);
        send_dibits(11, 0);
        send_idle(4);
        check_frame("runt", 0, 1'b0, 0, 1, 0);

        build_frame(5, 1'b0);
        frm[7] = 8'hD6;
        send_dibits(frm.size(), 0);
        send_idle(4);
        check_frame("bad_sfd", 0, 1'b0, 0, 1, 0);

        build_frame(64, 1'b0);
        send_dibits(frm.size(), 2);
        send_idle(4);
        check_frame("align", 64, 1'b1, 0, 1, 40);

        build_frame(5, 1'b0);
        send_dibits(10, 2);
        @(negedge clk);
        rst = 1'b1; rmii_en = 1'b0; rmii_clk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("midframe_reset_outputs", {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
                                       stat_rx_bad_fcs, stat_rx_err}, 0);
        rst = 1'b0;
        send_idle(3);
        check_frame("aborted", 0, 1'b0, 0, 0, 0);
        build_frame(5, 1'b0);
        send_dibits(frm.size(), 0);
        send_idle(4);
        check_frame("after_reset", 5, 1'b0, 0, 0, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
